// File: rtl/po2_multiply.sv
// ---------------------------------------------------------------------------
// po2_multiply
//   Multiplies a signed fixed-point operand by a signed power-of-two weight
//   (+/- 2^-k or exactly zero).
//
//   The operand is widened to 2*W bits and aligned to the Q(2I).(2(W-I))
//   product format. It is then shifted right one bit per clock until k_eff
//   shifts have been done. The shift is arithmetic and rounds toward minus
//   infinity. The sign of the weight is applied last, by two's-complement
//   negation.
//
//   rst doubles as the load strobe. Every rising edge with rst=1 captures
//   the operands and clears the outputs. The computation starts on the
//   first edge with rst=0. result_v rises k_eff+1 edges later, or 1 edge
//   later for a zero weight. After that, result and result_v are held
//   until the next rst.
//
// Parameters
//   W  operand / log_2_weight width; result is 2*W bits wide
//   I  integer bits of the signed input format Q(I).(W-I)
//
// Ports
//   clk              clock; all state changes on the rising edge
//   rst              synchronous active-high reset and load strobe
//   inp              signed multiplicand, Q(I).(W-I)
//   zero_weight      the weight is exactly zero
//   negative_weight  the weight is negative
//   log_2_weight     k, with weight magnitude 2^-k (unsigned)
//   result           registered signed product, Q(2I).(2(W-I))
//   result_v         registered result-valid flag
// ---------------------------------------------------------------------------
module po2_multiply #(
    parameter int W = 16,
    parameter int I = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     inp,
    input  logic             zero_weight,
    input  logic             negative_weight,
    input  logic [W-1:0]     log_2_weight,
    output logic [2*W-1:0]   result,
    output logic             result_v
);

    localparam int RW   = 2 * W;
    localparam int CW   = $clog2(RW);   // holds RW-1 without wrapping
    localparam int KMAX = RW - 1;

    typedef enum logic {
        SHIFT,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   acc, acc_nx, acc_load;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [CW-1:0]   k_eff, k_lat;
    logic            zw_lat, nw_lat;
    logic [RW-1:0]   result_nx;
    logic            result_v_nx;

    // Shifts past RW-1 cannot change the result any further. So k is
    // clamped before latching, which keeps the counter CW bits wide.
    always_comb begin
        k_eff = log_2_weight[CW-1:0];
        if (log_2_weight > W'(KMAX))
            k_eff = CW'(KMAX);
    end

    // Sign-extend to 2*W, then align the binary point to the product format.
    always_comb begin
        acc_load = {{W{inp[W-1]}}, inp} << (W - I);
    end

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        cnt_nx      = cnt;
        result_nx   = result;
        result_v_nx = result_v;
        case (state)
            SHIFT: begin
                if (zw_lat) begin
                    result_nx   = '0;
                    result_v_nx = 1'b1;
                    state_nx    = DONE;
                end else if (cnt == k_lat) begin
                    // Negation comes after the floor shift, so a negative
                    // weight gives -(floor(x)) rather than floor(-x).
                    result_nx   = nw_lat ? -acc : acc;
                    result_v_nx = 1'b1;
                    state_nx    = DONE;
                end else begin
                    acc_nx = {acc[RW-1], acc[RW-1:1]};
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                // hold result/result_v until the next rst
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SHIFT;
            acc      <= acc_load;
            cnt      <= '0;
            k_lat    <= k_eff;
            zw_lat   <= zero_weight;
            nw_lat   <= negative_weight;
            result   <= '0;
            result_v <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            result   <= result_nx;
            result_v <= result_v_nx;
        end
    end

endmodule

// File: tb/tb_po2_multiply.sv
// ---------------------------------------------------------------------------
// tb_po2_multiply
//   Self-checking bench for po2_multiply with W=16 and I=4.
//   Each load pushes the operation's expected product and latency onto a
//   queue. When result_v is seen, the oldest entry is popped and compared.
// ---------------------------------------------------------------------------
module tb_po2_multiply;

    localparam int W = 16;
    localparam int I = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     inp = '0;
    logic             zero_weight = 1'b0;
    logic             negative_weight = 1'b0;
    logic [W-1:0]     log_2_weight = '0;
    logic [2*W-1:0]   result;
    logic             result_v;

    always #5 clk = ~clk;

    po2_multiply #(.W(W), .I(I)) dut (
        .clk             (clk),
        .rst             (rst),
        .inp             (inp),
        .zero_weight     (zero_weight),
        .negative_weight (negative_weight),
        .log_2_weight    (log_2_weight),
        .result          (result),
        .result_v        (result_v)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference: value = sign * ((sext(a) << 12) >>> min(k,31)); zero weight -> 0
    function automatic exp_t model(logic [15:0] a, logic zw, logic nw, logic [15:0] k);
        exp_t   e;
        longint v;
        int     keff;
        keff = (k > 16'd31) ? 31 : int'(k);
        v = longint'($signed(a)) <<< (W - I);
        v = v >>> keff;
        if (nw) v = -v;
        if (zw) v = 0;
        e.res = v[31:0];
        e.lat = zw ? 1 : keff + 1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One load edge with rst=1; outputs must be cleared right after it.
    task automatic load(input logic [15:0] a, input logic zw, input logic nw, input logic [15:0] k);
        @(negedge clk);
        rst             = 1'b1;
        inp             = a;
        zero_weight     = zw;
        negative_weight = nw;
        log_2_weight    = k;
        @(posedge clk);
        #1;
        check("rst_result_v", 64'(result_v), 64'd0);
        check("rst_result", 64'(result), 64'd0);
    endtask

    task automatic start(input logic [15:0] a, input logic zw, input logic nw, input logic [15:0] k);
        load(a, zw, nw, k);
        sb.push_back(model(a, zw, nw, k));
        rst = 1'b0;
    endtask

    // Count edges until result_v, then check latency, value and hold.
    task automatic finish_op(input string tag, input bit scramble);
        exp_t e;
        int   n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (scramble) begin
                inp             = 16'($urandom);
                log_2_weight    = 16'($urandom);
                zero_weight     = 1'($urandom);
                negative_weight = 1'($urandom);
            end
            if (result_v === 1'b1) break;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(e.lat));
        check({tag, "_result"}, 64'(result), 64'(e.res));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_v"}, 64'(result_v), 64'd1);
        check({tag, "_hold_result"}, 64'(result), 64'(e.res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t dropped;

        // Directed cases
        start(16'h1000, 1'b0, 1'b0, 16'd1);   finish_op("k1_pos", 1'b0);
        start(16'h2000, 1'b0, 1'b1, 16'd2);   finish_op("k2_neg", 1'b0);
        start(16'hF000, 1'b0, 1'b0, 16'd0);   finish_op("k0_neg_inp", 1'b0);
        start(16'h7ABC, 1'b1, 1'b1, 16'd9);   finish_op("zero_w", 1'b0);
        start(16'h0001, 1'b0, 1'b0, 16'd13);  finish_op("floor_pos", 1'b0);
        start(16'hFFFF, 1'b0, 1'b1, 16'd13);  finish_op("floor_neg", 1'b0);
        start(16'h8000, 1'b0, 1'b0, 16'hFFFF); finish_op("k_clamp", 1'b0);
        start(16'h8000, 1'b0, 1'b1, 16'd31);  finish_op("k31_neg", 1'b0);

        // Abort mid-shift: no stale valid; the new operands must win.
        start(16'h1234, 1'b0, 1'b0, 16'd10);
        repeat (4) @(posedge clk);
        #1;
        check("mid_shift_v", 64'(result_v), 64'd0);
        dropped = sb.pop_front();
        start(16'hC321, 1'b0, 1'b1, 16'd3);   finish_op("after_abort", 1'b0);

        // rst held for several edges: only the last inputs count.
        load(16'h4000, 1'b0, 1'b0, 16'd5);
        load(16'h0F0F, 1'b1, 1'b0, 16'd7);
        start(16'h5555, 1'b0, 1'b0, 16'd4);   finish_op("rst_held", 1'b0);

        // Inputs scrambled during SHIFT must be ignored.
        start(16'hA5A5, 1'b0, 1'b1, 16'd6);   finish_op("scramble", 1'b1);

        // Random operands
        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra, rk;
            logic        rz, rn;
            ra = 16'($urandom);
            rk = 16'($urandom_range(0, 40));
            rz = ($urandom_range(0, 7) == 0);
            rn = 1'($urandom);
            start(ra, rz, rn, rk);
            finish_op("random", 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/po2_multiply.md
PO2_MULTIPLY -- requirements
Module: po2_multiply

Interface
REQ-001 Parameter W, default 16: width of inp and log_2_weight; result is 2*W wide.
REQ-002 Parameter I, default 4: integer bits of the signed fixed-point inp format; W-I fractional bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high; also acts as the load/start strobe.
REQ-005 inp  input  W, signed  multiplicand, Q(I).(W-I).
REQ-006 zero_weight  input  1  weight is exactly zero.
REQ-007 negative_weight  input  1  weight is negative.
REQ-008 log_2_weight  input  W, unsigned  k, where weight magnitude = 2^-k.
REQ-009 result  output  2*W, signed, registered  product, Q(2I).(2(W-I)).
REQ-010 result_v  output  1, registered  result valid.

Function
REQ-011 Computed value: result = s * ((sext(inp) << (W-I)) >>> k_eff); s = -1 if negative_weight else +1; result = 0 if zero_weight.
REQ-012 k_eff = min(log_2_weight, 2*W-1).
REQ-013 Arithmetic (sign-preserving, floor) right shift first, then two's-complement negation of the shifted value.
REQ-014 All arithmetic 2*W bits wide; no overflow is possible, no saturation logic.
REQ-015 Internal state: 2*W accumulator acc, shift counter, latched zero/negative/k_eff, FSM {SHIFT, DONE}.
REQ-016 Load: each edge with rst=1: acc <= sext(inp) << (W-I); counter <= 0; weight inputs latched; FSM <= SHIFT.
REQ-017 Inputs are sampled only while rst=1; changes after rst falls are ignored until the next rst.
REQ-018 SHIFT, latched zero_weight=1: result <= 0, result_v <= 1, go DONE (first edge after rst falls).
REQ-019 SHIFT, counter == k_eff: result <= s*acc, result_v <= 1, go DONE.
REQ-020 SHIFT otherwise: acc <= acc >>> 1, counter <= counter + 1; result_v stays 0.
REQ-021 Latency: result_v rises on the (k_eff+1)-th rising edge after the last edge with rst=1; one shift per cycle.
REQ-022 DONE: result and result_v held indefinitely until the next rst.
REQ-023 result_v is never asserted while rst=1 or during SHIFT.
REQ-024 Counter wide enough for 2*W-1 with no wrap-around.

Reset
REQ-025 Any edge with rst=1: result <= 0, result_v <= 0, plus the load of REQ-016.
REQ-026 rst=1 mid-SHIFT or in DONE aborts/clears the operation and starts a fresh load; no stale result_v.
REQ-027 rst held several cycles: last cycle's inputs win; computation starts on the first edge with rst=0.

Verification (W=16, I=4)
REQ-028 inp=0x1000, k=1, positive -> result=0x0080_0000, result_v on 2nd edge after rst falls.
REQ-029 inp=0x2000, k=2, negative -> result=0xFF80_0000, result_v on 3rd edge.
REQ-030 inp=0xF000, k=0, positive -> result=0xFF00_0000 on 1st edge; zero_weight=1 with any inp/k -> result=0 on 1st edge.
REQ-031 Rounding: inp=0x0001, k=13 -> 0; inp=0xFFFF, k=13, negative -> 0x0000_0001; k=0xFFFF -> k_eff=31, valid on 32nd edge.
REQ-032 Reset mid-operation: k=10, assert rst after 4 cycles -> result_v=0, result=0 next edge; new operands' result correct after rst falls.
REQ-033 Input change after rst falls (inp, k altered during SHIFT) -> result matches the operands latched at load.
